// File: rtl/cmul_sched.sv
// cmul_sched -- shared complex-multiplier scheduler for the 2D FFT.
//
// Time-shares one registered complex multiplier between requester A (row
// FFT engine) and requester B (column FFT engine). Operands are granted in
// bursts of up to BURST beats through valid/ready. Each issued product is
// tagged with its owner, so the result returns to the requester that issued it.
//
// Optional feature: define CMUL_SCHED_RR_EN for round-robin tie breaking.
// When it is undefined, A has fixed priority.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   a_valid/a_ready, a_r/a_i    requester A handshake and data operands
//   a_wr/a_wi                   requester A twiddle operands
//   b_*                         same set for requester B
//   m_in_r/m_in_i               registered data operands to the multiplier
//   m_w_real/m_w_imag           registered twiddle operands to the multiplier
//   m_out_r/m_out_i             multiplier results (MULT_LAT after operands)
//   res_r/res_i                 pass-through of multiplier results
//   a_res_valid/b_res_valid     result owner strobes (mutually exclusive)
//   busy                        product in flight or FSM not idle
module cmul_sched #(
   parameter int DW       = 16,
   parameter int WW       = 8,
   parameter int MULT_LAT = 2,
   parameter int BURST    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic signed [DW-1:0] a_r,
   input  logic signed [DW-1:0] a_i,
   input  logic signed [WW-1:0] a_wr,
   input  logic signed [WW-1:0] a_wi,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic signed [DW-1:0] b_r,
   input  logic signed [DW-1:0] b_i,
   input  logic signed [WW-1:0] b_wr,
   input  logic signed [WW-1:0] b_wi,
   output logic signed [DW-1:0] m_in_r,
   output logic signed [DW-1:0] m_in_i,
   output logic signed [WW-1:0] m_w_real,
   output logic signed [WW-1:0] m_w_imag,
   input  logic signed [DW-1:0] m_out_r,
   input  logic signed [DW-1:0] m_out_i,
   output logic signed [DW-1:0] res_r,
   output logic signed [DW-1:0] res_i,
   output logic                 a_res_valid,
   output logic                 b_res_valid,
   output logic                 busy
);

   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BURST_A = 2'd1,
      BURST_B = 2'd2
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [CW-1:0]   beat_cnt;
   logic            hs;          // operand handshake this cycle
   logic            owner;       // 1'b0 = A, 1'b1 = B
   logic            burst_end;
   logic            start;       // a burst begins next cycle
   logic            pick_valid;
   logic            pick_b;
   logic [MULT_LAT:0] tag_v;
   logic [MULT_LAT:0] tag_o;

`ifdef CMUL_SCHED_RR_EN
   logic            last_grant;  // 1'b0 = A, 1'b1 = B

   // Arbiter: on a tie, the requester that did not win last time goes next.
   always_comb begin
      pick_valid = a_valid | b_valid;
      if (a_valid && b_valid) begin
         pick_b = ~last_grant;
      end else begin
         pick_b = ~a_valid;
      end
   end

   // Last-grant register, updated at every burst start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (start) begin
         last_grant <= pick_b;
      end else begin
         last_grant <= last_grant;
      end
   end
`else
   // Arbiter: A has fixed priority, so B wins only when A is idle.
   always_comb begin
      pick_valid = a_valid | b_valid;
      pick_b     = ~a_valid;
   end
`endif

   // State register and beat counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         beat_cnt <= {CW{1'b0}};
      end else begin
         state <= next_state;
         if (start || next_state == IDLE) begin
            beat_cnt <= {CW{1'b0}};
         end else if (hs) begin
            beat_cnt <= beat_cnt + CW'(1);
         end else begin
            beat_cnt <= beat_cnt;
         end
      end
   end

   // Next-state logic. A burst ends after its last beat or as soon as its
   // requester drops valid. The arbiter then picks the successor directly,
   // so burst-to-burst handover has no bubble.
   always_comb begin
      next_state = state;
      start      = 1'b0;
      case (state)
         IDLE:    burst_end = 1'b1;
         BURST_A: burst_end = ~a_valid | (beat_cnt == LAST_BEAT);
         BURST_B: burst_end = ~b_valid | (beat_cnt == LAST_BEAT);
         default: burst_end = 1'b1;
      endcase
      if (burst_end) begin
         if (pick_valid) begin
            start      = 1'b1;
            next_state = pick_b ? BURST_B : BURST_A;
         end else begin
            next_state = IDLE;
         end
      end else begin
         next_state = state;
      end
   end

   // Output decode: ready comes from registered state only.
   always_comb begin
      a_ready = (state == BURST_A);
      b_ready = (state == BURST_B);
      hs      = (a_ready & a_valid) | (b_ready & b_valid);
      owner   = b_ready;
   end

   // Operand registers. A cycle without a handshake drives zeros.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_in_r   <= {DW{1'b0}};
         m_in_i   <= {DW{1'b0}};
         m_w_real <= {WW{1'b0}};
         m_w_imag <= {WW{1'b0}};
      end else if (hs && !owner) begin
         m_in_r   <= a_r;
         m_in_i   <= a_i;
         m_w_real <= a_wr;
         m_w_imag <= a_wi;
      end else if (hs && owner) begin
         m_in_r   <= b_r;
         m_in_i   <= b_i;
         m_w_real <= b_wr;
         m_w_imag <= b_wi;
      end else begin
         m_in_r   <= {DW{1'b0}};
         m_in_i   <= {DW{1'b0}};
         m_w_real <= {WW{1'b0}};
         m_w_imag <= {WW{1'b0}};
      end
   end

   // Tag pipeline. Stage 0 lines up with the operand registers, and the
   // last stage lines up with the multiplier output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_v <= {(MULT_LAT+1){1'b0}};
         tag_o <= {(MULT_LAT+1){1'b0}};
      end else begin
         tag_v[0] <= hs;
         tag_o[0] <= owner;
         for (int k = 1; k <= MULT_LAT; k++) begin
            tag_v[k] <= tag_v[k-1];
            tag_o[k] <= tag_o[k-1];
         end
      end
   end

   assign res_r       = m_out_r;
   assign res_i       = m_out_i;
   assign a_res_valid = tag_v[MULT_LAT] & ~tag_o[MULT_LAT];
   assign b_res_valid = tag_v[MULT_LAT] &  tag_o[MULT_LAT];
   assign busy        = (|tag_v) | (state != IDLE);

endmodule

// File: tb/tb_cmul_sched.sv
module tb_cmul_sched;

   localparam int DW = 16;
   localparam int WW = 8;
   localparam int MULT_LAT = 2;
   localparam int BURST = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_valid = 1'b0, b_valid = 1'b0;
   logic a_ready, b_ready;
   logic signed [DW-1:0] a_r = '0, a_i = '0, b_r = '0, b_i = '0;
   logic signed [WW-1:0] a_wr = '0, a_wi = '0, b_wr = '0, b_wi = '0;
   logic signed [DW-1:0] m_in_r, m_in_i, m_out_r, m_out_i, res_r, res_i;
   logic signed [WW-1:0] m_w_real, m_w_imag;
   logic a_res_valid, b_res_valid, busy;

   cmul_sched #(.DW(DW), .WW(WW), .MULT_LAT(MULT_LAT), .BURST(BURST)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_r(a_r), .a_i(a_i), .a_wr(a_wr), .a_wi(a_wi),
      .b_valid(b_valid), .b_ready(b_ready), .b_r(b_r), .b_i(b_i), .b_wr(b_wr), .b_wi(b_wi),
      .m_in_r(m_in_r), .m_in_i(m_in_i), .m_w_real(m_w_real), .m_w_imag(m_w_imag),
      .m_out_r(m_out_r), .m_out_i(m_out_i), .res_r(res_r), .res_i(res_i),
      .a_res_valid(a_res_valid), .b_res_valid(b_res_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Reference complex multiply used by the external multiplier stand-in
   function automatic logic [2*DW-1:0] cmul_f(logic signed [DW-1:0] r, logic signed [DW-1:0] i,
                                              logic signed [WW-1:0] wr, logic signed [WW-1:0] wi);
      int pr, pi;
      pr = (int'(r) * int'(wr) - int'(i) * int'(wi)) >>> (WW - 2);
      pi = (int'(r) * int'(wi) + int'(i) * int'(wr)) >>> (WW - 2);
      return {pr[DW-1:0], pi[DW-1:0]};
   endfunction

   // External multiplier: MULT_LAT register stages
   logic [MULT_LAT-1:0][2*DW-1:0] mpipe;
   always @(posedge clk) begin
      mpipe[0] <= cmul_f(m_in_r, m_in_i, m_w_real, m_w_imag);
      for (int k = 1; k < MULT_LAT; k++) mpipe[k] <= mpipe[k-1];
   end
   assign m_out_r = mpipe[MULT_LAT-1][2*DW-1:DW];
   assign m_out_i = mpipe[MULT_LAT-1][DW-1:0];

   typedef struct {
      int due;
      bit own_b;
      logic [DW-1:0] r;
      logic [DW-1:0] i;
   } exp_t;
   exp_t sbq[$];

   // Behavioural scheduler model: owner 0 = none, 1 = A, 2 = B
   int mown = 0;
   int mbeats = 0;
   int mlast = 2;
   int last_hs = -100;
   logic [2*DW+2*WW-1:0] exp_op = '0;

   always @(negedge clk) begin
      bit hs, ending, exp_busy;
      logic [2*DW+2*WW-1:0] op;
      logic [2*DW-1:0] p;
      if (rst) begin
         mown = 0; mbeats = 0; mlast = 2; last_hs = -100; exp_op = '0;
         sbq.delete();
      end else begin
         chk("a_ready", 64'(a_ready), 64'(mown == 1));
         chk("b_ready", 64'(b_ready), 64'(mown == 2));
         chk("operands", 64'({m_in_r, m_in_i, m_w_real, m_w_imag}), 64'(exp_op));
         exp_busy = (mown != 0) || ((cyc - last_hs) >= 1 && (cyc - last_hs) <= MULT_LAT + 1);
         chk("busy", 64'(busy), 64'(exp_busy));
         hs = (mown == 1 && a_valid) || (mown == 2 && b_valid);
         if (hs) begin
            op = (mown == 1) ? {a_r, a_i, a_wr, a_wi} : {b_r, b_i, b_wr, b_wi};
            p = (mown == 1) ? cmul_f(a_r, a_i, a_wr, a_wi) : cmul_f(b_r, b_i, b_wr, b_wi);
            sbq.push_back('{cyc + 1 + MULT_LAT, (mown == 2), p[2*DW-1:DW], p[DW-1:0]});
            exp_op = op;
            last_hs = cyc;
         end else begin
            exp_op = '0;
         end
         if (mown == 0 || !hs) begin
            ending = 1'b1;
         end else begin
            mbeats++;
            ending = (mbeats == BURST);
         end
         if (ending) begin
            mbeats = 0;
            if (a_valid && b_valid) begin
`ifdef CMUL_SCHED_RR_EN
               mown = (mlast == 1) ? 2 : 1;
`else
               mown = 1;
`endif
            end else if (a_valid) mown = 1;
            else if (b_valid) mown = 2;
            else mown = 0;
            if (mown != 0) mlast = mown;
         end
      end
   end

   // Result monitor: pops the scoreboard whenever a result strobe appears
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (a_res_valid || b_res_valid) begin
            if (sbq.size() == 0) begin
               chk("res_unexpected", 64'({a_res_valid, b_res_valid}), 64'd0);
            end else begin
               e = sbq.pop_front();
               chk("res_time", 64'(cyc), 64'(e.due));
               chk("res_owner", 64'({a_res_valid, b_res_valid}), e.own_b ? 64'd1 : 64'd2);
               chk("res_data", 64'({res_r, res_i}), 64'({e.r, e.i}));
            end
         end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk("res_missing", 64'(0), 64'(e.due));
         end
      end
   end

   task automatic randomize_data();
      a_r = DW'($urandom); a_i = DW'($urandom); a_wr = WW'($urandom); a_wi = WW'($urandom);
      b_r = DW'($urandom); b_i = DW'($urandom); b_wr = WW'($urandom); b_wi = WW'($urandom);
   endtask

   task automatic run_phase(int cycles, int pa, int pb);
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk); #1;
         a_valid = ($urandom_range(99) < pa);
         b_valid = ($urandom_range(99) < pb);
         randomize_data();
      end
   endtask

   task automatic idle(int cycles);
      @(posedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (cycles) @(posedge clk);
   endtask

   task automatic drive_a_count(int n);
      int cnt = 0;
      int k = 0;
      @(posedge clk); #1;
      b_valid = 1'b0;
      a_valid = 1'b1; a_r = 16'sd1; a_i = 16'sd0; a_wr = 8'sd64; a_wi = 8'sd0;
      while (cnt < n && k < 100) begin
         @(negedge clk);
         if (a_ready) cnt++;
         k++;
      end
      chk("a_stream_count", 64'(cnt), 64'(n));
      @(posedge clk); #1;
      a_valid = 1'b0;
   endtask

   task automatic check_all_zero(string nm);
      chk({nm, "_ready"}, 64'({a_ready, b_ready}), 64'd0);
      chk({nm, "_resv"}, 64'({a_res_valid, b_res_valid}), 64'd0);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_ops"}, 64'({m_in_r, m_in_i, m_w_real, m_w_imag}), 64'd0);
   endtask

   initial begin
      #2;
      check_all_zero("reset");
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;

      // A-only stream of six (1,0)x(64,0) operands
      drive_a_count(6);
      idle(8);

      // Both requesters continuously valid
      run_phase(30, 100, 100);
      idle(6);

      // A drops out two beats into its burst while B stays valid
      @(posedge clk); #1;
      a_valid = 1'b1; b_valid = 1'b1; randomize_data();
      repeat (3) @(posedge clk);
      #1 a_valid = 1'b0;
      repeat (6) @(posedge clk);
      idle(6);

      // Random traffic mixes
      run_phase(300, 60, 60);
      run_phase(150, 90, 30);
      run_phase(150, 25, 85);
      idle(6);

      // Asynchronous reset with products in flight
      run_phase(7, 100, 100);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk); #2;
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check_all_zero("post_rst");

      // Traffic resumes after reset
      run_phase(100, 70, 70);
      idle(8);
      @(negedge clk);
      chk("sb_drained", 64'(sbq.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
